maxnet_ctrl: RTL and testbench
==============================

# maxnet_ctrl

Iteration controller for the four-PU MaxNet array. It drives the PU input side (shared activation bus, `mul_en`, `sum_en`). It consumes the PU result side (`pu_out`, `s` from each of four PUs). Each iteration's activations are fed back until exactly one PU stays non-zero, all go to zero, or an iteration limit is hit. It sits between the top-level start/result handshake and the PU array; PU weights stay outside this block.

## Interface
- `MAX_ITER`, 31: iteration limit; range 1..(2^`ITER_W`−1).
- `ITER_W`, 5: width of the iteration counter.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `start` in 1: request a run. Sampled only in IDLE.
- `a1`..`a4` in 5 each: initial activations, captured on accepted `start`.
- `x1`..`x4` out 5 each: current activations, broadcast to all PUs.
- `mul_en` out 1: PU multiplier-register load strobe.
- `sum_en` out 1: PU sum-register load strobe.
- `pu_out1`..`pu_out4` in 5 each: PU ReLU outputs.
- `s1`..`s4` in 1 each: PU non-zero flags.
- `busy` out 1: high from the cycle after an accepted `start` until DONE is left.
- `done` out 1: one-cycle pulse when results become valid.
- `winner` out 2: index 0..3 of the winning PU.
- `winner_val` out 5: activation of the winning PU.
- `no_winner` out 1: all activations reached zero.
- `timeout` out 1: `MAX_ITER` iterations ran with no resolution.
- `iter_count` out `ITER_W`: number of iterations completed.

## Operation
- States: IDLE, MUL, SUM, EVAL, DONE.
- IDLE:
  - `start`=1 → capture `a1..a4` into the x registers, clear `iter_count` and all result flags, go to MUL.
  - `start`=0 → stay in IDLE.
- MUL: `mul_en`=1 for exactly this cycle → SUM.
- SUM: `sum_en`=1 for exactly this cycle → EVAL.
- EVAL: sample `s1..s4`, form the ones-count `n`, `iter_count` += 1.
  - n==1: `winner` = index of the set `s`, `winner_val` = matching `pu_out` → DONE.
  - n==0: `no_winner`=1, `winner`=0, `winner_val`=0 → DONE.
  - n≥2 and the incremented count == `MAX_ITER`: `timeout`=1. `winner` = index of the largest `pu_out`, lowest index on a tie; `winner_val` = that value → DONE.
  - Otherwise: x registers ← `pu_out1..4`, go to MUL.
- DONE: `done`=1 for one cycle → IDLE. Result outputs and the x registers hold until the next accepted `start`.
- `start` while `busy` is ignored, with no effect on state or data.
- `mul_en` and `sum_en` are never high in the same cycle, and neither is high outside MUL or SUM.
- Exactly one of {n==1, `no_winner`, `timeout`} explains each `done`. `timeout` and `no_winner` are never both 1.
- Arithmetic: activations are unsigned 5-bit and fed back unmodified. This block performs no saturation; the PU handles it.

## Timing
- Reset (`rst`=1 at a clock edge): state=IDLE. `x1..x4`=0, `mul_en`=`sum_en`=0, `busy`=0, `done`=0, `winner`=0, `winner_val`=0, `no_winner`=0, `timeout`=0, `iter_count`=0.
- Reset mid-run aborts immediately. No `done` is produced, and the next cycle is IDLE.
- `start` accepted at edge t:
  - MUL occupies cycle t+1 and SUM cycle t+2.
  - EVAL occupies cycle t+3; PU outputs must be valid combinationally in EVAL.
  - Each iteration takes 3 cycles.
  - `done` is high in cycle t+1+3k for k iterations.
- A new `start` is accepted at the earliest in the cycle after DONE (in IDLE).
- `busy` is registered: high in MUL, SUM, EVAL and DONE, low in IDLE.

## Structure
- Package `maxnet_pkg`:
  - state enum;
  - `NUM_PU`=4, `DATA_W`=5;
  - default `MAX_ITER`/`ITER_W`.
- One sub-module `nz_encoder`. Combinational; takes `s1..s4` and produces the ones-count (3 bits) and the lowest set index (2 bits).
- The max-select used on timeout stays inline.

## Test plan
- Bench uses a scripted PU model. It returns programmed `pu_out`/`s` in EVAL and checks that the strobes arrive in MUL then SUM.
- Single winner:
  - Stimulus: `start` with a=(5,3,2,1); PU returns (4,0,0,0) with s=1000 in the first EVAL.
  - Required: `done` 4 cycles after `start`, `winner`=0, `winner_val`=4, `iter_count`=1, flags 0.
- Multi-iteration with feedback:
  - Stimulus: a=(9,8,6,1). Iteration 1 returns (7,5,2,0); iteration 2 returns (0,0,3,0) with s=0010.
  - Required: `x1..x4`=(7,5,2,0) during the second MUL. `done` at t+7 with `winner`=2, `winner_val`=3, `iter_count`=2.
- All zero:
  - Stimulus: PU returns s=0000.
  - Required: `no_winner`=1, `winner`=0, `winner_val`=0, `timeout`=0.
- Timeout with tie, `MAX_ITER`=3:
  - Stimulus: PU always returns (6,6,2,0) with s=1110.
  - Required: `done` at t+10, `timeout`=1, `winner`=0, `winner_val`=6, `iter_count`=3.
- Control edges:
  - Stimulus: `start` pulsed during SUM; then `rst` asserted in EVAL of a run; then `start` held for 2 cycles in IDLE.
  - Required: the mid-run `start` is ignored. After the reset edge, all outputs match the reset values and no `done` appears. Exactly one run launches from the held `start`, with `busy`=1 from the next cycle.

Source files
------------

// File: rtl/maxnet_pkg.sv
// Shared types and sizing for the MaxNet iteration controller.
package maxnet_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    MUL  = 3'd1,
    SUM  = 3'd2,
    EVAL = 3'd3,
    DONE = 3'd4
  } state_e;

  localparam int NUM_PU       = 4;
  localparam int DATA_W       = 5;
  localparam int DEF_MAX_ITER = 31;
  localparam int DEF_ITER_W   = 5;

endpackage

// File: rtl/nz_encoder.sv
// Ones-count and lowest-set index of the four PU non-zero flags.
module nz_encoder (
  input  logic       s1,
  input  logic       s2,
  input  logic       s3,
  input  logic       s4,
  output logic [2:0] count,
  output logic [1:0] low_idx
);

  always_comb begin
    count = 3'(s1) + 3'(s2) + 3'(s3) + 3'(s4);
    // Highest index first so the lowest set flag wins.
    low_idx = 2'd0;
    if (s4) low_idx = 2'd3;
    if (s3) low_idx = 2'd2;
    if (s2) low_idx = 2'd1;
    if (s1) low_idx = 2'd0;
  end

endmodule

// File: rtl/maxnet_ctrl.sv
// MaxNet iteration controller: feeds activations to four PUs and resolves a winner.
// Handshake: start is a single-cycle request honoured only in IDLE; done pulses once when results are valid.
module maxnet_ctrl
  import maxnet_pkg::*;
#(
  parameter int MAX_ITER = DEF_MAX_ITER,
  parameter int ITER_W   = DEF_ITER_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] a1,
  input  logic [DATA_W-1:0] a2,
  input  logic [DATA_W-1:0] a3,
  input  logic [DATA_W-1:0] a4,
  output logic [DATA_W-1:0] x1,
  output logic [DATA_W-1:0] x2,
  output logic [DATA_W-1:0] x3,
  output logic [DATA_W-1:0] x4,
  output logic              mul_en,
  output logic              sum_en,
  input  logic [DATA_W-1:0] pu_out1,
  input  logic [DATA_W-1:0] pu_out2,
  input  logic [DATA_W-1:0] pu_out3,
  input  logic [DATA_W-1:0] pu_out4,
  input  logic              s1,
  input  logic              s2,
  input  logic              s3,
  input  logic              s4,
  output logic              busy,
  output logic              done,
  output logic [1:0]        winner,
  output logic [DATA_W-1:0] winner_val,
  output logic              no_winner,
  output logic              timeout,
  output logic [ITER_W-1:0] iter_count,
  output state_e            dbg_state
);

  state_e            state, state_next;
  logic              busy_q;
  logic [DATA_W-1:0] x_q [NUM_PU];
  logic [DATA_W-1:0] pu  [NUM_PU];
  logic [2:0]        nz_count;
  logic [1:0]        nz_idx;
  logic [ITER_W-1:0] iter_inc;
  logic              last_iter;
  logic [1:0]        max_idx;
  logic [DATA_W-1:0] max_val;

  assign pu[0] = pu_out1;
  assign pu[1] = pu_out2;
  assign pu[2] = pu_out3;
  assign pu[3] = pu_out4;

  nz_encoder u_nz_encoder (
    .s1      (s1),
    .s2      (s2),
    .s3      (s3),
    .s4      (s4),
    .count   (nz_count),
    .low_idx (nz_idx)
  );

  assign iter_inc  = iter_count + ITER_W'(1);
  assign last_iter = (iter_inc == ITER_W'(MAX_ITER));

  // Strict greater-than keeps the lowest index on ties.
  always_comb begin
    max_idx = 2'd0;
    max_val = pu[0];
    for (int i = 1; i < NUM_PU; i++) begin
      if (pu[i] > max_val) begin
        max_idx = 2'(i);
        max_val = pu[i];
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = MUL;
      MUL:     state_next = SUM;
      SUM:     state_next = EVAL;
      EVAL:    state_next = (nz_count <= 3'd1 || last_iter) ? DONE : MUL;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      busy_q <= 1'b0;
    end else begin
      state  <= state_next;
      busy_q <= (state_next != IDLE);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_PU; i++) x_q[i] <= '0;
      iter_count <= '0;
      winner     <= 2'd0;
      winner_val <= '0;
      no_winner  <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            x_q[0]     <= a1;
            x_q[1]     <= a2;
            x_q[2]     <= a3;
            x_q[3]     <= a4;
            iter_count <= '0;
            winner     <= 2'd0;
            winner_val <= '0;
            no_winner  <= 1'b0;
            timeout    <= 1'b0;
          end
        end
        EVAL: begin
          iter_count <= iter_inc;
          if (nz_count == 3'd1) begin
            winner     <= nz_idx;
            winner_val <= pu[nz_idx];
          end else if (nz_count == 3'd0) begin
            no_winner  <= 1'b1;
            winner     <= 2'd0;
            winner_val <= '0;
          end else if (last_iter) begin
            timeout    <= 1'b1;
            winner     <= max_idx;
            winner_val <= max_val;
          end else begin
            for (int i = 0; i < NUM_PU; i++) x_q[i] <= pu[i];
          end
        end
        default: ;
      endcase
    end
  end

  assign x1        = x_q[0];
  assign x2        = x_q[1];
  assign x3        = x_q[2];
  assign x4        = x_q[3];
  assign mul_en    = (state == MUL);
  assign sum_en    = (state == SUM);
  assign done      = (state == DONE);
  assign busy      = busy_q;
  assign dbg_state = state;

endmodule

// File: tb/tb_maxnet_ctrl.sv
// Bench for maxnet_ctrl: scripted PU model, cycle-by-cycle strobe checks, result scoreboard.
module tb_maxnet_ctrl;
  import maxnet_pkg::*;

  localparam int MAXI = 3;
  localparam int ITW  = 5;
  localparam int W    = 14;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [4:0] a_v  [4];
  logic [4:0] pu_v [4];
  logic [3:0] s_v;

  wire logic [4:0]     x1, x2, x3, x4;
  wire logic           mul_en, sum_en, busy, done, no_winner, timeout;
  wire logic [1:0]     winner;
  wire logic [4:0]     winner_val;
  wire logic [ITW-1:0] iter_count;
  wire state_e         dbg_state;
  logic [4:0]          x_v [4];

  assign x_v[0] = x1;
  assign x_v[1] = x2;
  assign x_v[2] = x3;
  assign x_v[3] = x4;

  maxnet_ctrl #(.MAX_ITER(MAXI), .ITER_W(ITW)) dut (
    .clk(clk), .rst(rst), .start(start),
    .a1(a_v[0]), .a2(a_v[1]), .a3(a_v[2]), .a4(a_v[3]),
    .x1(x1), .x2(x2), .x3(x3), .x4(x4),
    .mul_en(mul_en), .sum_en(sum_en),
    .pu_out1(pu_v[0]), .pu_out2(pu_v[1]), .pu_out3(pu_v[2]), .pu_out4(pu_v[3]),
    .s1(s_v[0]), .s2(s_v[1]), .s3(s_v[2]), .s4(s_v[3]),
    .busy(busy), .done(done), .winner(winner), .winner_val(winner_val),
    .no_winner(no_winner), .timeout(timeout), .iter_count(iter_count),
    .dbg_state(dbg_state)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // Scoreboard state
  int total = 0;
  int bad   = 0;
  logic [W-1:0] exp_q[$];

  // PU script: response for each iteration; s bit i is the flag of PU i+1
  logic [4:0] scr_pu [MAXI][4];
  logic [3:0] scr_s  [MAXI];

  // Reference model outputs
  int         m_k, m_winner, m_val;
  bit         m_nw, m_to;
  logic [4:0] x_seq [MAXI][4];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] pack_res(int w, int v, bit nw, bit to, int k);
    return {2'(w), 5'(v), nw, to, 5'(k)};
  endfunction

  // Walks the rules directly: x fed back until one flag, no flags, or the limit.
  task automatic model_run();
    logic [4:0] cur [4];
    logic [4:0] mx;
    int n;
    cur = a_v;
    m_nw = 0; m_to = 0; m_winner = 0; m_val = 0; m_k = 0;
    for (int it = 0; it < MAXI; it++) begin
      for (int j = 0; j < 4; j++) x_seq[it][j] = cur[j];
      n = $countones(scr_s[it]);
      m_k = it + 1;
      if (n == 1) begin
        for (int j = 0; j < 4; j++)
          if (scr_s[it][j]) begin m_winner = j; m_val = scr_pu[it][j]; end
        break;
      end
      if (n == 0) begin m_nw = 1; break; end
      if (it + 1 == MAXI) begin
        m_to = 1;
        mx = 0;
        for (int j = 0; j < 4; j++) if (scr_pu[it][j] > mx) mx = scr_pu[it][j];
        for (int j = 3; j >= 0; j--) if (scr_pu[it][j] == mx) m_winner = j;
        m_val = mx;
        break;
      end
      cur = scr_pu[it];
    end
  endtask

  task automatic check_reset_vals(input string pfx);
    check({pfx, "_state"}, 32'(dbg_state), 32'(IDLE));
    for (int j = 0; j < 4; j++) check({pfx, "_x"}, 32'(x_v[j]), 32'd0);
    check({pfx, "_mul_en"}, 32'(mul_en), 32'd0);
    check({pfx, "_sum_en"}, 32'(sum_en), 32'd0);
    check({pfx, "_busy"}, 32'(busy), 32'd0);
    check({pfx, "_done"}, 32'(done), 32'd0);
    check({pfx, "_result"}, 32'({winner, winner_val, no_winner, timeout, iter_count}), 32'd0);
  endtask

  task automatic rand_a();
    for (int j = 0; j < 4; j++) a_v[j] = 5'($urandom_range(0, 31));
  endtask

  task automatic rand_script();
    for (int it = 0; it < MAXI; it++) begin
      for (int j = 0; j < 4; j++) begin
        scr_pu[it][j] = ($urandom_range(0, 2) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        scr_s[it][j]  = (scr_pu[it][j] != 5'd0);
      end
    end
  endtask

  task automatic set_iter(input int it, input int p0, input int p1, input int p2, input int p3,
                          input logic [3:0] s);
    scr_pu[it][0] = 5'(p0); scr_pu[it][1] = 5'(p1);
    scr_pu[it][2] = 5'(p2); scr_pu[it][3] = 5'(p3);
    scr_s[it] = s;
  endtask

  // Drives one run and checks every cycle. glitch_c: cycle of a stray start;
  // rst_c: cycle in which rst is raised (run aborted); hold: start kept for 2 cycles.
  task automatic do_run(input int glitch_c, input int rst_c, input bit hold);
    int last, phase, it;
    bit in_run;
    logic [W-1:0] exp_r;
    state_e exp_st;
    model_run();
    last = 3 * m_k + 1;
    if (rst_c == 0) exp_q.push_back(pack_res(m_winner, m_val, m_nw, m_to, m_k));
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    for (int c = 1; c <= last + 1; c++) begin
      if (c == 1 && !hold) start = 1'b0;
      if (c == 1 && hold) rand_a();
      if (c == 2) start = 1'b0;
      if (c == glitch_c) begin start = 1'b1; rand_a(); end
      if (c == glitch_c + 1) start = 1'b0;
      in_run = (c < last);
      phase = (c - 1) % 3;
      it = (c - 1) / 3;
      if (in_run) exp_st = (phase == 0) ? MUL : (phase == 1) ? SUM : EVAL;
      else if (c == last) exp_st = DONE;
      else exp_st = IDLE;
      check("state", 32'(dbg_state), 32'(exp_st));
      check("mul_en", 32'(mul_en), 32'(in_run && phase == 0));
      check("sum_en", 32'(sum_en), 32'(in_run && phase == 1));
      check("done", 32'(done), 32'(c == last));
      check("busy", 32'(busy), 32'(c <= last));
      if (in_run && phase == 0)
        for (int j = 0; j < 4; j++) check("x_in_mul", 32'(x_v[j]), 32'(x_seq[it][j]));
      if (in_run && phase == 2) begin
        pu_v = scr_pu[it];
        s_v  = scr_s[it];
      end else begin
        for (int j = 0; j < 4; j++) pu_v[j] = 5'($urandom_range(0, 31));
        s_v = 4'($urandom_range(0, 15));
      end
      if (c == rst_c) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset_vals("abort");
        for (int k = 0; k < 4; k++) begin
          @(negedge clk);
          check("abort_no_done", 32'(done), 32'd0);
          check("abort_idle", 32'(busy), 32'd0);
        end
        return;
      end
      if (c == last) begin
        exp_r = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
        check("result", 32'({winner, winner_val, no_winner, timeout, iter_count}), 32'(exp_r));
        check("flag_excl", 32'(no_winner & timeout), 32'd0);
      end
      if (c == last + 1)
        check("result_hold", 32'({winner, winner_val, no_winner, timeout, iter_count}),
              32'(pack_res(m_winner, m_val, m_nw, m_to, m_k)));
      @(negedge clk);
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    s_v = 4'd0;
    for (int j = 0; j < 4; j++) begin a_v[j] = 5'd0; pu_v[j] = 5'd0; end
    repeat (2) @(negedge clk);
    check_reset_vals("reset");
    rst = 1'b0;
    @(negedge clk);

    // Single winner in the first iteration
    a_v[0] = 5'd5; a_v[1] = 5'd3; a_v[2] = 5'd2; a_v[3] = 5'd1;
    set_iter(0, 4, 0, 0, 0, 4'b0001);
    set_iter(1, 1, 1, 0, 0, 4'b0011);
    set_iter(2, 1, 1, 0, 0, 4'b0011);
    do_run(0, 0, 1'b0);

    // Two iterations with feedback
    a_v[0] = 5'd9; a_v[1] = 5'd8; a_v[2] = 5'd6; a_v[3] = 5'd1;
    set_iter(0, 7, 5, 2, 0, 4'b0111);
    set_iter(1, 0, 0, 3, 0, 4'b0100);
    do_run(0, 0, 1'b0);

    // All zero
    rand_a();
    set_iter(0, 0, 0, 0, 0, 4'b0000);
    do_run(0, 0, 1'b0);

    // Timeout with a tie on the largest value
    rand_a();
    for (int it = 0; it < MAXI; it++) set_iter(it, 6, 6, 2, 0, 4'b0111);
    do_run(0, 0, 1'b0);

    // Stray start during SUM of a two-iteration run
    a_v[0] = 5'd9; a_v[1] = 5'd8; a_v[2] = 5'd6; a_v[3] = 5'd1;
    set_iter(0, 7, 5, 2, 0, 4'b0111);
    set_iter(1, 0, 0, 3, 0, 4'b0100);
    do_run(2, 0, 1'b0);

    // Reset in EVAL aborts the run
    rand_a();
    set_iter(0, 3, 0, 0, 0, 4'b0001);
    do_run(0, 3, 1'b0);

    // Start held for two cycles launches exactly one run
    rand_a();
    set_iter(0, 0, 2, 0, 0, 4'b0010);
    do_run(0, 0, 1'b1);

    for (int r = 0; r < 40; r++) begin
      rand_a();
      rand_script();
      do_run(($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0, 0, 1'b0);
    end

    check("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
